// File: rtl/four_bit_addr_sub.sv
// Registered WIDTH-bit two's-complement adder/subtractor with carry-out and signed overflow.
// Optional zero flag output z is enabled by defining ADDRSUB_ZERO_FLAG_EN.

module addsub_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module four_bit_addr_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
    output logic             c4,
    output logic             v,
`ifdef ADDRSUB_ZERO_FLAG_EN
    output logic             z,
`endif
    output logic             out_valid
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;

    // c0 doubles as mode select and carry-in: inverting b and adding one gives A-B.
    assign b_eff = b ^ {WIDTH{c0}};
    assign c[0]  = c0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        addsub_fa_cell u_fa (
            .a_i (a[i]),
            .b_i (b_eff[i]),
            .c_i (c[i]),
            .s_o (sum[i]),
            .c_o (c[i+1])
        );
    end

    logic [WIDTH-1:0] s_q, s_d;
    logic             c4_q, c4_d;
    logic             v_q, v_d;
    logic             vld_q, vld_d;

    always_comb begin
        s_d   = s_q;
        c4_d  = c4_q;
        v_d   = v_q;
        vld_d = in_valid;
        if (in_valid) begin
            s_d  = sum;
            c4_d = c[WIDTH];
            v_d  = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            c4_q  <= 1'b0;
            v_q   <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            c4_q  <= c4_d;
            v_q   <= v_d;
            vld_q <= vld_d;
        end
    end

    assign s         = s_q;
    assign c4        = c4_q;
    assign v         = v_q;
    assign out_valid = vld_q;

`ifdef ADDRSUB_ZERO_FLAG_EN
    logic z_q, z_d;

    always_comb begin
        z_d = z_q;
        if (in_valid) z_d = (sum == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) z_q <= 1'b0;
        else        z_q <= z_d;
    end

    assign z = z_q;
`endif
endmodule

// File: tb/tb_four_bit_addr_sub.sv
// Self-checking bench for four_bit_addr_sub: table vectors, random stream, hold and reset cases.

module tb_four_bit_addr_sub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         c0;
    logic [W-1:0] s;
    logic         c4, v, out_valid;
`ifdef ADDRSUB_ZERO_FLAG_EN
    logic         z;
`endif

    four_bit_addr_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c0        (c0),
        .s         (s),
        .c4        (c4),
        .v         (v),
`ifdef ADDRSUB_ZERO_FLAG_EN
        .z         (z),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c4;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c0;
        logic [W-1:0] s;
        logic         c4;
        logic         v;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t last_exp;
    exp_t cur;
    logic cap, rst_at;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model from integer arithmetic, independent of the ripple structure.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t e;
        int ua = int'(av);
        int ub = int'(bv);
        int sa = int'($signed(av));
        int sb = int'($signed(bv));
        int full, rs;
        if (cv) begin
            full = ua - ub;
            rs   = sa - sb;
            e.c4 = (ua >= ub);
        end else begin
            full = ua + ub;
            rs   = sa + sb;
            e.c4 = (full >= (1 << W));
        end
        e.s = full[W-1:0];
        e.v = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".s"},  32'(s),  32'(e.s));
        chk({tag, ".c4"}, 32'(c4), 32'(e.c4));
        chk({tag, ".v"},  32'(v),  32'(e.v));
`ifdef ADDRSUB_ZERO_FLAG_EN
        chk({tag, ".z"},  32'(z),  32'(e.z));
`endif
    endtask

    // Monitor: samples controls at the edge, checks outputs 1ns later.
    always @(posedge clk) begin
        cap    = in_valid && rst_n;
        rst_at = rst_n;
        #1;
        if (!rst_at) begin
            last_exp = '{s: '0, c4: 1'b0, v: 1'b0, z: 1'b0};
            chk("rst.out_valid", 32'(out_valid), 32'd0);
            check_out("rst", last_exp);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(cap));
            if (cap) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    cur      = sb_q.pop_front();
                    last_exp = cur;
                    check_out("result", cur);
                end
            end else begin
                check_out("hold", last_exp);
            end
        end
    end

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic vld, input exp_t e);
        @(negedge clk);
        a = av; b = bv; c0 = cv; in_valid = vld;
        if (vld) sb_q.push_back(e);
    endtask

    task automatic drive_model(input logic vld);
        logic [W-1:0] av, bv;
        logic         cv;
        av = W'($urandom);
        bv = W'($urandom);
        cv = 1'($urandom);
        drive(av, bv, cv, vld, model(av, bv, cv));
    endtask

    task automatic idle();
        drive_model(1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        exp_t e;
        vecs[0] = '{a: 4'b1110, b: 4'b0101, c0: 1'b1, s: 4'b1001, c4: 1'b1, v: 1'b0};
        vecs[1] = '{a: 4'b0111, b: 4'b0001, c0: 1'b0, s: 4'b1000, c4: 1'b0, v: 1'b1};
        vecs[2] = '{a: 4'b1111, b: 4'b0001, c0: 1'b0, s: 4'b0000, c4: 1'b1, v: 1'b0};
        vecs[3] = '{a: 4'b0011, b: 4'b0101, c0: 1'b1, s: 4'b1110, c4: 1'b0, v: 1'b0};
        vecs[4] = '{a: 4'b1000, b: 4'b0001, c0: 1'b1, s: 4'b0111, c4: 1'b1, v: 1'b1};
        vecs[5] = '{a: 4'b0000, b: 4'b0000, c0: 1'b1, s: 4'b0000, c4: 1'b1, v: 1'b0};
        vecs[6] = '{a: 4'b1000, b: 4'b1000, c0: 1'b0, s: 4'b0000, c4: 1'b1, v: 1'b1};
        vecs[7] = '{a: 4'b0101, b: 4'b0011, c0: 1'b0, s: 4'b1000, c4: 1'b0, v: 1'b1};

        last_exp = '{s: '0, c4: 1'b0, v: 1'b0, z: 1'b0};
        rst_n = 1'b0; in_valid = 1'b1; a = 4'b1010; b = 4'b0110; c0 = 1'b1;
        #1;
        chk("rst0.out_valid", 32'(out_valid), 32'd0);
        check_out("rst0", last_exp);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, each followed by an idle cycle with new operands to check hold.
        for (int i = 0; i < 8; i++) begin
            e = '{s: vecs[i].s, c4: vecs[i].c4, v: vecs[i].v, z: (vecs[i].s == '0)};
            drive(vecs[i].a, vecs[i].b, vecs[i].c0, 1'b1, e);
            idle();
        end

        // Back-to-back captures, then a run of idle cycles.
        for (int i = 0; i < 30; i++) drive_model(1'b1);
        for (int i = 0; i < 4; i++) idle();

        // Random mix of captures and gaps.
        for (int i = 0; i < 40; i++) drive_model(1'($urandom_range(0, 2) != 0));
        idle();

        // Mid-stream reset clears a valid result without any clock edge.
        drive_model(1'b1);
        drive_model(1'b1);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        check_out("midrst", '{s: '0, c4: 1'b0, v: 1'b0, z: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        drive(4'b1111, 4'b0001, 1'b0, 1'b1, '{s: 4'b0000, c4: 1'b1, v: 1'b0, z: 1'b1});
        idle();
        idle();

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/four_bit_addr_sub.md
Name: four_bit_addr_sub

Overview:
- Registered WIDTH-bit (default 4) two's-complement adder/subtractor with carry-out and signed-overflow flags.
- Mode is selected by c0: 0 = add, 1 = subtract (b inverted, c0 used as carry-in).
- Sits in the lab datapath as a single-cycle arithmetic unit between operand registers and the result/flag display.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; capture on rising clk when high.
- a  input  WIDTH  operand A, two's complement / unsigned.
- b  input  WIDTH  operand B.
- c0  input  1  mode and carry-in; 0 = A+B, 1 = A-B.
- s  output  WIDTH  registered result.
- c4  output  1  registered carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
- v  output  1  registered signed overflow.
- out_valid  output  1  registered; high the cycle after an in_valid capture.

Behaviour:
- Reset: rst_n low asynchronously forces s=0, c4=0, v=0, out_valid=0. Outputs hold these values until the first capture after rst_n deasserts.
- Combinational core:
  - b_eff[i] = b[i] XOR c0.
  - Ripple chain of WIDTH full-adder cells; carry into bit 0 is c0.
  - sum[i] = a[i] ^ b_eff[i] ^ c[i].
  - c[i+1] = a[i]&b_eff[i] | c[i]&(a[i]^b_eff[i]).
  - c4 = c[WIDTH]; v = c[WIDTH] XOR c[WIDTH-1].
- Latency: exactly 1 cycle. On a rising clk with in_valid=1, s/c4/v are loaded from the core and out_valid is set to 1.
- With in_valid=0: s/c4/v hold their previous values and out_valid drops to 0.
- No backpressure; a new capture may occur every cycle (full throughput).
- Arithmetic wraps modulo 2^WIDTH; there is no saturation.
- rst_n asserted mid-stream discards any pending result immediately. The first in_valid after release produces out_valid one cycle later.
- Operand changes while in_valid=0 have no effect on the outputs.

Optional Feature:
- Macro ADDRSUB_ZERO_FLAG_EN.
- Defined: adds output port z (1 bit), registered alongside s. z=1 iff the captured sum is all zeros. z resets to 0 and holds while in_valid=0.
- Undefined: port z does not exist. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> s=0000, c4=0, v=0, out_valid=0 immediately, without any clock edge.
- Subtract: a=1110, b=0101, c0=1, in_valid=1 -> next cycle s=1001, c4=1, v=0, out_valid=1.
- Add signed overflow: a=0111, b=0001, c0=0 -> s=1000, c4=0, v=1.
- Add carry/wrap: a=1111, b=0001, c0=0 -> s=0000, c4=1, v=0; z=1 when ADDRSUB_ZERO_FLAG_EN is defined.
- Subtract borrow: a=0011, b=0101, c0=1 -> s=1110, c4=0, v=0.
- Subtract overflow: a=1000, b=0001, c0=1 -> s=0111, c4=1, v=1.
- Hold and back-to-back: captures on consecutive cycles -> results follow one per cycle. Then in_valid=0 with new operands -> outputs unchanged, out_valid=0.
